// File: rtl/blt_parcyc_pkg.sv
// Shared types and constants for the blitter parameter-read responder.
// BLT_PAR_WORD_EN selects 16-bit word fetches (pointer steps by 2) instead of byte fetches.
package blt_par_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACC  = 2'd2,
    ST_CEND = 2'd3
  } par_state_e;

  localparam int WAIT_ST_MAX = 7;
  localparam int WCNT_W      = 3;

`ifdef BLT_PAR_WORD_EN
  localparam int PTR_INC    = 2;
  localparam int PAR_DATA_W = 16;
`else
  localparam int PTR_INC    = 1;
  localparam int PAR_DATA_W = 8;
`endif

endpackage

// File: rtl/blt_parcyc_if.sv
// Requester/arbiter/memory side signals of the parameter-read responder.
// The responder connects through the slave modport.
interface blt_parcyc_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = blt_par_pkg::PAR_DATA_W
) ();

  logic              parcrq;
  logic              ldpadr;
  logic [ADDR_W-1:0] padrin;
  logic              mgnt;
  logic [DATA_W-1:0] mdin;
  logic              mreq;
  logic              mrd;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] pdata;
  logic              icycend;
  logic              cycend;

  modport master (
    output parcrq, ldpadr, padrin, mgnt, mdin,
    input  mreq, mrd, maddr, pdata, icycend, cycend
  );

  modport slave (
    input  parcrq, ldpadr, padrin, mgnt, mdin,
    output mreq, mrd, maddr, pdata, icycend, cycend
  );

endinterface

// File: rtl/blt_parcyc_ptr.sv
// Parameter fetch pointer: load, auto-increment with natural wrap.
// Under BLT_PAR_WORD_EN a loaded odd pointer is rounded down to a word boundary.
module blt_parptr
  import blt_par_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              cclk,
  input  logic              sreset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] load_aligned;

`ifdef BLT_PAR_WORD_EN
  assign load_aligned = load_val & ~ADDR_W'(1);
`else
  assign load_aligned = load_val;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge cclk) begin
    if (sreset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_aligned;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(PTR_INC);
    end
  end

endmodule

// File: rtl/blt_parcyc.sv
// Parameter-read responder: runs arbitrated memory reads for PARCRQ and returns cycle timing.
// BLT_PAR_WORD_EN enables word fetches (DATA_W=16, MADDR[0]=0, pointer += 2).
module blt_parcyc
  import blt_par_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = PAR_DATA_W,
  parameter int WAIT_ST = 1
) (
  input  logic        cclk,
  input  logic        sreset,
  blt_parcyc_if.slave bus
);

  localparam int WAIT_EFF = (WAIT_ST > WAIT_ST_MAX) ? WAIT_ST_MAX : WAIT_ST;

  par_state_e        state, state_nx;
  logic [WCNT_W-1:0] wcnt;
  logic [DATA_W-1:0] pdata_q;
  logic              cycend_q;
  logic [ADDR_W-1:0] ptr;
  logic              icycend;
  logic              ptr_load;

  assign icycend  = (state == ST_ACC) && (wcnt == '0);
  // Pointer loads are only honoured while idle; once busy it only increments.
  assign ptr_load = (state == ST_IDLE) && bus.ldpadr;

  blt_parptr #(.ADDR_W(ADDR_W)) u_ptr (
    .cclk     (cclk),
    .sreset   (sreset),
    .load     (ptr_load),
    .load_val (bus.padrin),
    .inc      (icycend),
    .ptr      (ptr)
  );

  // NOTE: the default at the top of the block keeps state_nx assigned on every
  // path, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.parcrq) state_nx = ST_REQ;
      ST_REQ: begin
        if (!bus.parcrq)   state_nx = ST_IDLE;
        else if (bus.mgnt) state_nx = ST_ACC;
      end
      ST_ACC:  if (wcnt == '0) state_nx = ST_CEND;
      ST_CEND: begin
        if (bus.parcrq && bus.mgnt) state_nx = ST_ACC;
        else if (bus.parcrq)        state_nx = ST_REQ;
        else                        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (sreset) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      pdata_q  <= '0;
      cycend_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cycend_q <= icycend;
      if (state_nx == ST_ACC && state != ST_ACC) begin
        wcnt <= WCNT_W'(WAIT_EFF);
      end else if (state == ST_ACC && wcnt != '0) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
      if (icycend) pdata_q <= bus.mdin;
    end
  end

  // In CEND the request is look-ahead: keep the bus only if another fetch follows.
  assign bus.mreq    = (state == ST_REQ) || (state == ST_ACC) ||
                       ((state == ST_CEND) && bus.parcrq);
  assign bus.mrd     = (state == ST_ACC);
  assign bus.icycend = icycend;
  assign bus.cycend  = cycend_q;
  assign bus.pdata   = pdata_q;

`ifdef BLT_PAR_WORD_EN
  assign bus.maddr = ptr & ~ADDR_W'(1);
`else
  assign bus.maddr = ptr;
`endif

endmodule

// File: tb/tb_blt_parcyc.sv
// Self-checking bench for blt_parcyc: scoreboard of expected (address, data) per fetch.
// Build with BLT_PAR_WORD_EN defined to exercise the word-fetch variant.
module tb_blt_parcyc;

  localparam int AW = 20;
`ifdef BLT_PAR_WORD_EN
  localparam int DW   = 16;
  localparam int STEP = 2;
`else
  localparam int DW   = 8;
  localparam int STEP = 1;
`endif
  localparam int CLKS_PER_FETCH = 3;  // WAIT_ST=1: two access clocks + one CEND clock

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic cclk;
  logic sreset;
  int   total;
  int   bad;
  exp_t sb[$];

  blt_parcyc_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  blt_parcyc #(.ADDR_W(AW), .DATA_W(DW), .WAIT_ST(1)) dut (
    .cclk   (cclk),
    .sreset (sreset),
    .bus    (bus)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic test_reset();
    sreset = 1'b1;
    repeat (2) @(posedge cclk);
    @(negedge cclk);
    total++; if (bus.mreq !== 1'b0)    begin bad++; $display("FAIL reset_mreq got=%b exp=0", bus.mreq); end
    total++; if (bus.mrd !== 1'b0)     begin bad++; $display("FAIL reset_mrd got=%b exp=0", bus.mrd); end
    total++; if (bus.icycend !== 1'b0) begin bad++; $display("FAIL reset_icycend got=%b exp=0", bus.icycend); end
    total++; if (bus.cycend !== 1'b0)  begin bad++; $display("FAIL reset_cycend got=%b exp=0", bus.cycend); end
    total++; if (bus.maddr !== '0)     begin bad++; $display("FAIL reset_maddr got=%h exp=0", bus.maddr); end
    total++; if (bus.pdata !== '0)     begin bad++; $display("FAIL reset_pdata got=%h exp=0", bus.pdata); end
    sreset = 1'b0;
  endtask

  // Loads start, holds PARCRQ with MGNT=1 for n fetches, scoreboards address/data.
  task automatic do_burst(input string name, input logic [AW-1:0] start, input int n,
                          input logic [DW-1:0] d0, input logic [DW-1:0] dstep);
    logic [AW-1:0] a;
    exp_t          e;
    int            busy = 0;
    int            ic = 0;
    int            ce = 0;
    int            cyc = 0;
    a = start;
    if (STEP == 2) a[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{addr: a, data: d0 + DW'(i) * dstep});
      a = a + AW'(STEP);
    end
    @(negedge cclk);
    bus.ldpadr = 1'b1;
    bus.padrin = start;
    bus.parcrq = 1'b1;
    bus.mgnt   = 1'b1;
    bus.mdin   = sb[0].data;
    @(negedge cclk);
    bus.ldpadr = 1'b0;
    while (ce < n && cyc < 60) begin
      if (bus.mrd || bus.cycend) busy++;
      total++;
      if ((bus.icycend & bus.cycend) !== 1'b0) begin
        bad++; $display("FAIL %s_overlap icycend=%b cycend=%b exp not both", name, bus.icycend, bus.cycend);
      end
      if (bus.cycend === 1'b1) begin
        ce++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL %s_sb_empty got=cycend exp=no pending fetch", name);
        end else begin
          e = sb.pop_front();
          if (bus.pdata !== e.data) begin
            bad++; $display("FAIL %s_pdata got=%h exp=%h", name, bus.pdata, e.data);
          end
        end
      end
      if (bus.icycend === 1'b1) begin
        ic++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL %s_extra_icycend got=pulse exp=none", name);
        end else if (bus.maddr !== sb[0].addr) begin
          bad++; $display("FAIL %s_maddr got=%h exp=%h", name, bus.maddr, sb[0].addr);
        end
        if (ic == n) bus.parcrq = 1'b0;
      end
      bus.mdin = (sb.size() != 0) ? sb[0].data : '0;
      cyc++;
      if (ce < n) @(negedge cclk);
    end
    total++; if (ce != n) begin bad++; $display("FAIL %s_timeout cycend_pulses=%0d exp=%0d", name, ce, n); end
    total++; if (ic != n) begin bad++; $display("FAIL %s_icycend_count got=%0d exp=%0d", name, ic, n); end
    total++; if (busy != n * CLKS_PER_FETCH) begin
      bad++; $display("FAIL %s_clocks got=%0d exp=%0d", name, busy, n * CLKS_PER_FETCH);
    end
    bus.mgnt = 1'b0;
    sb.delete();
    @(negedge cclk);
    total++; if (bus.mreq !== 1'b0) begin bad++; $display("FAIL %s_idle_mreq got=%b exp=0", name, bus.mreq); end
    total++; if (bus.maddr !== a)   begin bad++; $display("FAIL %s_final_maddr got=%h exp=%h", name, bus.maddr, a); end
  endtask

  task automatic test_fetch3();
    do_burst("fetch3", 20'h01230, 3, DW'(8'h11), DW'(8'h11));
  endtask

  task automatic test_no_grant();
    logic [AW-1:0] exp_addr;
    int            hi = 0;
    int            rd = 0;
    exp_addr = 20'h01230 + AW'(3 * STEP);
    bus.mgnt   = 1'b0;
    bus.parcrq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge cclk);
      if (bus.mreq === 1'b1) hi++;
      if (bus.mrd !== 1'b0) rd++;
      if (i == 4) bus.parcrq = 1'b0;
    end
    total++; if (hi != 5)  begin bad++; $display("FAIL nogrant_mreq_clocks got=%0d exp=5", hi); end
    total++; if (rd != 0)  begin bad++; $display("FAIL nogrant_mrd got=%0d exp=0", rd); end
    total++; if (bus.mreq !== 1'b0) begin bad++; $display("FAIL nogrant_idle got=%b exp=0", bus.mreq); end
    total++; if (bus.maddr !== exp_addr) begin
      bad++; $display("FAIL nogrant_maddr got=%h exp=%h", bus.maddr, exp_addr);
    end
  endtask

  task automatic test_wrap();
    do_burst("wrap", 20'hFFFFF, 1, DW'(8'h5A), DW'(0));
  endtask

  task automatic test_back_to_back();
    do_burst("b2b", 20'h00200, 4, DW'(8'hA0), DW'(8'h07));
  endtask

  task automatic test_reset_mid_acc();
    int seen = 0;
    @(negedge cclk);
    bus.ldpadr = 1'b1;
    bus.padrin = 20'h00040;
    bus.parcrq = 1'b1;
    bus.mgnt   = 1'b1;
    @(negedge cclk);
    bus.ldpadr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mrd === 1'b1) break;
      @(negedge cclk);
    end
    total++; if (bus.mrd !== 1'b1) begin bad++; $display("FAIL rstacc_wait_mrd got=%b exp=1", bus.mrd); end
    sreset = 1'b1;
    @(negedge cclk);
    total++; if (bus.mreq !== 1'b0)    begin bad++; $display("FAIL rstacc_mreq got=%b exp=0", bus.mreq); end
    total++; if (bus.mrd !== 1'b0)     begin bad++; $display("FAIL rstacc_mrd got=%b exp=0", bus.mrd); end
    total++; if (bus.maddr !== '0)     begin bad++; $display("FAIL rstacc_maddr got=%h exp=0", bus.maddr); end
    sreset     = 1'b0;
    bus.parcrq = 1'b0;
    bus.mgnt   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.icycend !== 1'b0) seen++;
      @(negedge cclk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstacc_icycend got=%0d exp=0", seen); end
  endtask

`ifdef BLT_PAR_WORD_EN
  task automatic test_word();
    do_burst("word", 20'h00101, 2, 16'h1234, 16'h1111);
  endtask
`endif

  initial begin
    total      = 0;
    bad        = 0;
    sreset     = 1'b0;
    bus.parcrq = 1'b0;
    bus.ldpadr = 1'b0;
    bus.padrin = '0;
    bus.mgnt   = 1'b0;
    bus.mdin   = '0;
    test_reset();
    test_fetch3();
    test_no_grant();
    test_wrap();
    test_back_to_back();
    test_reset_mid_acc();
`ifdef BLT_PAR_WORD_EN
    test_word();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
